// File: rtl/ropuf_race_sequencer.sv
// Race sequencer for a ring-oscillator PUF counter pair: clears, arms and runs
// each RO pair in turn, then compares the settled counts into one response bit.
module ropuf_race_sequencer #(
  parameter  int CW      = 4,
  parameter  int NBITS   = 8,
  parameter  int SETTLE  = 4,
  parameter  int TIMEOUT = 1024,
  localparam int SW      = (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [CW-1:0]    COUNT1,
  input  logic [CW-1:0]    COUNT2,
  output logic             CNT_RST,
  output logic             CNT_EN,
  output logic [SW-1:0]    CHAL_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic [NBITS-1:0] RESP,
  output logic             RESP_VALID,
  output logic [NBITS-1:0] TIE,
  output logic [NBITS-1:0] TMO
);

  localparam int MAXC = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int TW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ARM, S_RUN, S_SETTLE, S_SAMPLE, S_DECIDE, S_FIN
  } state_t;

  state_t           state_reg, state_next;
  logic [TW-1:0]    cnt_reg, cnt_next;
  logic [SW-1:0]    sel_reg, sel_next;
  logic [NBITS-1:0] resp_reg, resp_next;
  logic [NBITS-1:0] tie_reg, tie_next;
  logic [NBITS-1:0] tmo_reg, tmo_next;
  logic [CW-1:0]    c1_reg, c1_next;
  logic [CW-1:0]    c2_reg, c2_next;
  logic             valid_reg, valid_next;
  logic [1:0]       sync_reg;
  logic             cnt_rst_reg, cnt_en_reg, busy_reg, done_reg;
  logic             sat_raw, sat_s;

  // Only the 1-bit saturation flag crosses while the counters run.
  assign sat_raw = (&COUNT1) | (&COUNT2);
  assign sat_s   = sync_reg[1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      sel_reg     <= '0;
      resp_reg    <= '0;
      tie_reg     <= '0;
      tmo_reg     <= '0;
      c1_reg      <= '0;
      c2_reg      <= '0;
      valid_reg   <= 1'b0;
      sync_reg    <= '0;
      cnt_rst_reg <= 1'b1;
      cnt_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      resp_reg    <= resp_next;
      tie_reg     <= tie_next;
      tmo_reg     <= tmo_next;
      c1_reg      <= c1_next;
      c2_reg      <= c2_next;
      valid_reg   <= valid_next;
      sync_reg    <= {sync_reg[0], sat_raw};
      // Counter-pair controls are registered so they never glitch into the RO domain.
      cnt_rst_reg <= (state_next == S_IDLE) || (state_next == S_CLR);
      cnt_en_reg  <= (state_next == S_RUN);
      busy_reg    <= (state_next != S_IDLE) && (state_next != S_FIN);
      done_reg    <= (state_next == S_FIN);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    sel_next   = sel_reg;
    resp_next  = resp_reg;
    tie_next   = tie_reg;
    tmo_next   = tmo_reg;
    c1_next    = c1_reg;
    c2_next    = c2_reg;
    valid_next = valid_reg;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          state_next = S_CLR;
          resp_next  = '0;
          tie_next   = '0;
          tmo_next   = '0;
          sel_next   = '0;
          valid_next = 1'b0;
        end
      end
      S_CLR:    if (cnt_reg == TW'(1)) state_next = S_ARM;
      S_ARM:    if (cnt_reg == TW'(1)) state_next = S_RUN;
      S_RUN: begin
        if (sat_s) begin
          state_next = S_SETTLE;
        end else if (cnt_reg == TW'(TIMEOUT - 1)) begin
          tmo_next[sel_reg] = 1'b1;
          state_next        = S_SETTLE;
        end
      end
      S_SETTLE: if (cnt_reg == TW'(SETTLE - 1)) state_next = S_SAMPLE;
      S_SAMPLE: begin
        c1_next    = COUNT1;
        c2_next    = COUNT2;
        state_next = S_DECIDE;
      end
      S_DECIDE: begin
        resp_next[sel_reg] = (c1_reg > c2_reg);
        tie_next[sel_reg]  = (c1_reg == c2_reg);
        if (sel_reg == SW'(NBITS - 1)) begin
          valid_next = 1'b1;
          state_next = S_FIN;
        end else begin
          sel_next   = sel_reg + 1'b1;
          state_next = S_CLR;
        end
      end
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    // Every state measures its dwell time from zero.
    if ((state_next != state_reg) || (state_reg == S_IDLE)) cnt_next = '0;
  end

  assign CNT_RST    = cnt_rst_reg;
  assign CNT_EN     = cnt_en_reg;
  assign CHAL_SEL   = sel_reg;
  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign RESP       = resp_reg;
  assign RESP_VALID = valid_reg;
  assign TIE        = tie_reg;
  assign TMO        = tmo_reg;

endmodule

// File: tb/tb_ropuf_race_sequencer.sv
// Bench for ropuf_race_sequencer: emulates the RO counter pair per pair and
// checks responses against table vectors and a race-outcome model.
module tb_ropuf_race_sequencer;
  localparam int CW = 4, NBITS = 8, SETTLE = 4, TIMEOUT = 1024;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] count1 = '0, count2 = '0;
  logic cnt_rst, cnt_en, busy, done, resp_valid;
  logic [2:0] chal_sel;
  logic [7:0] resp, tie, tmo;

  ropuf_race_sequencer #(.CW(CW), .NBITS(NBITS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RESET(rst), .START(start), .COUNT1(count1), .COUNT2(count2),
    .CNT_RST(cnt_rst), .CNT_EN(cnt_en), .CHAL_SEL(chal_sel), .BUSY(busy),
    .DONE(done), .RESP(resp), .RESP_VALID(resp_valid), .TIE(tie), .TMO(tmo));

  always #5 clk = ~clk;

  // Per-pair oscillator: period in CLK cycles per count, 0 = dead (stuck at st).
  int per1[8], per2[8], st1[8], st2[8];
  int ph1 = 0, ph2 = 0;
  int errors = 0, checks = 0;

  always @(posedge clk) begin
    if (per1[int'(chal_sel)] == 0) count1 <= 4'(st1[int'(chal_sel)]);
    else if (cnt_rst) begin count1 <= '0; ph1 <= 0; end
    else if (cnt_en && count1 != 4'hF) begin
      if (ph1 >= per1[int'(chal_sel)] - 1) begin count1 <= count1 + 1'b1; ph1 <= 0; end
      else ph1 <= ph1 + 1;
    end
    if (per2[int'(chal_sel)] == 0) count2 <= 4'(st2[int'(chal_sel)]);
    else if (cnt_rst) begin count2 <= '0; ph2 <= 0; end
    else if (cnt_en && count2 != 4'hF) begin
      if (ph2 >= per2[int'(chal_sel)] - 1) begin count2 <= count2 + 1'b1; ph2 <= 0; end
      else ph2 <= ph2 + 1;
    end
  end

  // Observer: run lengths, post-race quiet time, invariant violations, DONE count.
  int run_len[8], settle_len[8];
  int viol_ovl = 0, viol_sel = 0, done_total = 0;
  int en_cnt = 0, low_cnt = 0, fall_sel = 0;
  bit pending = 0, prev_en = 0, prev_busy = 0;
  logic [2:0] prev_sel = '0;
  always @(negedge clk) begin
    if (!prev_busy && busy) begin
      for (int i = 0; i < 8; i++) begin run_len[i] = -1; settle_len[i] = -1; end
      viol_ovl = 0; viol_sel = 0;
    end
    if (cnt_en && cnt_rst) viol_ovl++;
    if ((cnt_en || prev_en) && chal_sel != prev_sel) viol_sel++;
    if (cnt_en) en_cnt++;
    if (pending) begin
      if (cnt_rst || done) begin settle_len[fall_sel] = low_cnt; pending = 0; end
      else low_cnt++;
    end
    if (prev_en && !cnt_en) begin
      fall_sel = int'(prev_sel); run_len[fall_sel] = en_cnt;
      en_cnt = 0; low_cnt = 1; pending = !rst;
    end
    if (done) done_total++;
    prev_en = cnt_en; prev_busy = busy; prev_sel = chal_sel;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] fast1, eq, dead;
    logic [7:0] exp_resp, exp_tie, exp_tmo;
  } vec_t;
  vec_t vecs[4];

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      st1[i] = 0; st2[i] = 0;
      if (v.dead[i]) begin per1[i] = 0; per2[i] = 0; st1[i] = 3; st2[i] = 0; end
      else if (v.eq[i]) begin per1[i] = 2; per2[i] = 2; end
      else if (v.fast1[i]) begin per1[i] = 1; per2[i] = 2; end
      else begin per1[i] = 2; per2[i] = 1; end
    end
  endtask

  // Race outcome: faster live ring wins; equal rates saturate together (tie);
  // both dead means timeout and the stuck values are compared.
  task automatic model(output logic [7:0] r, output logic [7:0] t, output logic [7:0] m);
    r = '0; t = '0; m = '0;
    for (int i = 0; i < 8; i++) begin
      if (per1[i] != 0 && per2[i] != 0) begin
        r[i] = (per1[i] < per2[i]);
        t[i] = (per1[i] == per2[i]);
      end else if (per1[i] != 0 || per2[i] != 0) begin
        r[i] = (per1[i] != 0);
      end else begin
        m[i] = 1'b1;
        r[i] = (st1[i] > st2[i]);
        t[i] = (st1[i] == st2[i]);
      end
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_run_on_sel(input logic [2:0] s);
    bit ok = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (cnt_en && chal_sel == s) begin ok = 1; break; end
    end
    check("run_reached", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input logic [7:0] er, input logic [7:0] et,
                            input logic [7:0] em, input int d0);
    int bad = 0;
    wait_done();
    check({tag, "_resp"}, 32'(resp), 32'(er));
    check({tag, "_tie"}, 32'(tie), 32'(et));
    check({tag, "_tmo"}, 32'(tmo), 32'(em));
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_total - d0), 32'd1);
    check({tag, "_en_rst_overlap"}, 32'(viol_ovl), 32'd0);
    check({tag, "_sel_while_en"}, 32'(viol_sel), 32'd0);
    for (int i = 0; i < 8; i++) if (settle_len[i] != SETTLE + 2) bad++;
    check({tag, "_settle_pairs_bad"}, 32'(bad), 32'd0);
    for (int i = 0; i < 8; i++)
      if (em[i]) check({tag, "_timeout_run_len"}, 32'(run_len[i]), 32'(TIMEOUT));
    $display("run %s resp=%02h tie=%02h tmo=%02h (exp %02h %02h %02h)", tag, resp, tie, tmo, er, et, em);
  endtask

  initial begin
    logic [7:0] er, et, em;
    int d0;
    vecs[0] = '{fast1: 8'h55, eq: 8'h00, dead: 8'h00, exp_resp: 8'h55, exp_tie: 8'h00, exp_tmo: 8'h00};
    vecs[1] = '{fast1: 8'h55, eq: 8'h20, dead: 8'h00, exp_resp: 8'h55, exp_tie: 8'h20, exp_tmo: 8'h00};
    vecs[2] = '{fast1: 8'h55, eq: 8'h00, dead: 8'h02, exp_resp: 8'h57, exp_tie: 8'h00, exp_tmo: 8'h02};
    vecs[3] = '{fast1: 8'hAA, eq: 8'h81, dead: 8'h00, exp_resp: 8'h2A, exp_tie: 8'h81, exp_tmo: 8'h00};
    for (int i = 0; i < 8; i++) begin per1[i] = 0; per2[i] = 0; st1[i] = 0; st2[i] = 0; end

    repeat (3) @(negedge clk);
    check("rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_busy_done_valid", 32'({busy, done, resp_valid}), 32'd0);
    check("rst_sel", 32'(chal_sel), 32'd0);
    check("rst_words", 32'({resp, tie, tmo}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table vectors
    for (int v = 0; v < 4; v++) begin
      load_vec(vecs[v]);
      d0 = done_total;
      pulse_start();
      check("start_busy", 32'(busy), 32'd1);
      finish_run($sformatf("vec%0d", v), vecs[v].exp_resp, vecs[v].exp_tie, vecs[v].exp_tmo, d0);
    end

    // START during RUN and on the DONE cycle are both ignored
    load_vec(vecs[0]);
    d0 = done_total;
    pulse_start();
    wait_run_on_sel(3'd2);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_valid", 32'(resp_valid), 32'd1);
    check("ign_done_count", 32'(done_total - d0), 32'd1);
    check("ign_resp", 32'(resp), 32'h55);
    $display("run ignored-starts done_count=%0d resp=%02h", done_total - d0, resp);

    // START on the cycle after DONE is accepted
    load_vec(vecs[1]);
    d0 = done_total;
    pulse_start();
    wait_done();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid_drop", 32'(resp_valid), 32'd0);
    check("b2b_resp_clear", 32'({resp, tie}), 32'd0);
    finish_run("b2b", 8'h55, 8'h20, 8'h00, d0 + 1);

    // Randomized pairs against the race model
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) begin
        int m = int'($urandom_range(0, 5));
        st1[i] = int'($urandom_range(0, 14));
        st2[i] = ($urandom_range(0, 2) == 0) ? st1[i] : int'($urandom_range(0, 14));
        per1[i] = (m == 0 || m == 1) ? 0 : int'($urandom_range(1, 4));
        per2[i] = (m == 0 || m == 2) ? 0 : int'($urandom_range(1, 4));
      end
      model(er, et, em);
      d0 = done_total;
      pulse_start();
      finish_run($sformatf("rand%0d", r), er, et, em, d0);
    end

    // RESET in the middle of pair 3
    load_vec(vecs[0]);
    d0 = done_total;
    pulse_start();
    wait_run_on_sel(3'd3);
    rst = 1'b1;
    #1;
    check("midrst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("midrst_cnt_en", 32'(cnt_en), 32'd0);
    check("midrst_sel", 32'(chal_sel), 32'd0);
    check("midrst_flags", 32'({busy, done, resp_valid}), 32'd0);
    check("midrst_words", 32'({resp, tie, tmo}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst_no_done", 32'(done_total - d0), 32'd0);
    check("midrst_idle", 32'({busy, resp_valid, cnt_rst}), 32'd1);
    $display("run midreset done_count=%0d busy=%0d", done_total - d0, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
